mmio_router: RTL and testbench

Parametrised data-port address router between the pipeline memory stage and NUM_DEV memory-mapped devices (vmem, timer, keyboard, loader, ...).
- Generalises the hard-wired 4-region decode and ad-hoc per-device stall counters into one request/ack handshake with a uniform stall, timeout and bus-error reporting.
- Addresses matching no device region pass straight through to the data cache.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_decode.sv | 25 ++
 rtl/mmio_router.sv | 155 +++++++++++++++
 tb/tb_mmio_router.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO data-port router: FSM encoding and default region map.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Default device region tags, matched against word address bits [29:26]
  localparam logic [3:0] VMEM_TAG   = 4'hC;
  localparam logic [3:0] TIMER_TAG  = 4'hD;
  localparam logic [3:0] KBD_TAG    = 4'hE;
  localparam logic [3:0] LOADER_TAG = 4'hF;

  localparam logic [31:0] DEFAULT_TAGS     = {16'h0000, LOADER_TAG, KBD_TAG, TIMER_TAG, VMEM_TAG};
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mmio_decode.sv
// Region decoder: compares the address tag against every device tag, lowest index wins.
module mmio_decode import mmio_pkg::*; #(
  parameter int unsigned NUM_DEV     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter logic [31:0] REGION_TAGS = DEFAULT_TAGS
) (
  input  logic [3:0]       tag,
  input  logic             access,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  // Scan from the top down so the lowest matching index is the last to write sel
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
      if (access && (tag == REGION_TAGS[4*i +: 4])) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_router.sv
// Data-port router: device accesses go through a request/ack handshake with timeout,
// everything else passes straight to the data cache.
module mmio_router import mmio_pkg::*; #(
  parameter int unsigned NUM_DEV     = 4,
  parameter logic [31:0] REGION_TAGS = DEFAULT_TAGS,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [29:0]           cpu_addr,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_byte_en,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_stall,
  output logic                  dc_read,
  output logic                  dc_write,
  input  logic [31:0]           dc_rdata,
  output logic [NUM_DEV-1:0]    dev_req,
  output logic                  dev_we,
  output logic [29:0]           dev_addr,
  output logic [31:0]           dev_wdata,
  output logic [3:0]            dev_byte_en,
  input  logic [32*NUM_DEV-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]    dev_ack,
  output logic                  bus_err,
  output logic [29:0]           err_addr
);

  localparam int unsigned SEL_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rdata_q;
  logic [NUM_DEV-1:0] dev_req_q;
  logic               dev_we_q;
  logic [29:0]        dev_addr_q;
  logic [31:0]        dev_wdata_q;
  logic [3:0]         dev_byte_en_q;
  logic               bus_err_q;
  logic [29:0]        err_addr_q;

  logic               hit;
  logic [SEL_W-1:0]   hit_sel;
  logic               ack_sel;
  logic [31:0]        rdata_sel;
  logic               timeout;

  mmio_decode #(
    .NUM_DEV     (NUM_DEV),
    .SEL_W       (SEL_W),
    .REGION_TAGS (REGION_TAGS)
  ) u_decode (
    .tag    (cpu_addr[29:26]),
    .access (cpu_read | cpu_write),
    .hit    (hit),
    .sel    (hit_sel)
  );

  // Pick out ack and read data of the latched channel; other channels are ignored
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_sel   = dev_ack[i];
        rdata_sel = dev_rdata[32*i +: 32];
      end
    end
  end

  // Last allowed BUSY cycle: counter would reach TIMEOUT on this edge
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Transaction FSM with registered device-side outputs and sticky error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      dev_req_q     <= '0;
      dev_we_q      <= 1'b0;
      dev_addr_q    <= '0;
      dev_wdata_q   <= '0;
      dev_byte_en_q <= '0;
      bus_err_q     <= 1'b0;
      err_addr_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hit) begin
            state_q       <= StBusy;
            sel_q         <= hit_sel;
            cnt_q         <= '0;
            dev_req_q     <= NUM_DEV'(1) << hit_sel;
            dev_we_q      <= cpu_write;
            dev_addr_q    <= cpu_addr;
            dev_wdata_q   <= cpu_wdata;
            dev_byte_en_q <= cpu_byte_en;
          end
        end
        StBusy: begin
          // Ack takes priority over a coincident timeout
          if (ack_sel) begin
            rdata_q   <= rdata_sel;
            dev_req_q <= '0;
            state_q   <= StDone;
          end else if (timeout) begin
            rdata_q   <= ERR_DATA;
            bus_err_q <= 1'b1;
            if (!bus_err_q) begin
              err_addr_q <= dev_addr_q;
            end
            cnt_q     <= cnt_q + 1'b1;
            dev_req_q <= '0;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Stall depends only on state and decode so a late ack cannot create a timing path to it
  always_comb begin
    cpu_stall = 1'b0;
    if (!rst) begin
      cpu_stall = (state_q == StBusy) || ((state_q == StIdle) && hit);
    end
  end

  assign dc_read     = cpu_read & ~hit;
  assign dc_write    = cpu_write & ~hit;
  assign cpu_rdata   = (hit || (state_q != StIdle)) ? rdata_q : dc_rdata;
  assign dev_req     = dev_req_q;
  assign dev_we      = dev_we_q;
  assign dev_addr    = dev_addr_q;
  assign dev_wdata   = dev_wdata_q;
  assign dev_byte_en = dev_byte_en_q;
  assign bus_err     = bus_err_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mmio_router.sv
// Self-checking bench for mmio_router: transaction-level model plus per-cycle compare.
module tb_mmio_router;

  localparam int unsigned NDEV = 5;
  localparam int unsigned TMO  = 16;
  // dev4 duplicates dev1's tag (D) so it must never be selected
  localparam logic [31:0] TAGS = 32'h000D_FEDC;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst;
  logic [29:0]         cpu_addr;
  logic                cpu_read, cpu_write;
  logic [31:0]         cpu_wdata;
  logic [3:0]          cpu_byte_en;
  logic [31:0]         cpu_rdata;
  logic                cpu_stall, dc_read, dc_write;
  logic [31:0]         dc_rdata;
  logic [NDEV-1:0]     dev_req;
  logic                dev_we;
  logic [29:0]         dev_addr;
  logic [31:0]         dev_wdata;
  logic [3:0]          dev_byte_en;
  logic [32*NDEV-1:0]  dev_rdata;
  logic [NDEV-1:0]     dev_ack;
  logic                bus_err;
  logic [29:0]         err_addr;

  mmio_router #(
    .NUM_DEV     (NDEV),
    .REGION_TAGS (TAGS),
    .TIMEOUT     (TMO),
    .ERR_DATA    (ERRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_wdata   (cpu_wdata),
    .cpu_byte_en (cpu_byte_en),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .dc_read     (dc_read),
    .dc_write    (dc_write),
    .dc_rdata    (dc_rdata),
    .dev_req     (dev_req),
    .dev_we      (dev_we),
    .dev_addr    (dev_addr),
    .dev_wdata   (dev_wdata),
    .dev_byte_en (dev_byte_en),
    .dev_rdata   (dev_rdata),
    .dev_ack     (dev_ack),
    .bus_err     (bus_err),
    .err_addr    (err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle outputs, set by the driver before the sampling edge
  bit              chk_en, in_rst, chk_rdata, chk_lat;
  logic            exp_stall, exp_dc_read, exp_dc_write, exp_we, exp_bus_err;
  logic [NDEV-1:0] exp_req;
  logic [31:0]     exp_rdata, exp_wdata;
  logic [29:0]     exp_addr, exp_err_addr;
  logic [3:0]      exp_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest device index whose tag matches, or -1 for cache traffic
  function automatic int model_sel(input logic [29:0] a, input logic acc);
    logic [31:0] t;
    t = TAGS;
    if (!acc) return -1;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (a[29:26] == t[4*i +: 4]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (in_rst) begin
      check("stall_in_rst", {31'b0, cpu_stall}, 32'h0);
    end else if (chk_en) begin
      check("stall", {31'b0, cpu_stall}, {31'b0, exp_stall});
      check("dev_req", {27'b0, dev_req}, {27'b0, exp_req});
      check("dc_read", {31'b0, dc_read}, {31'b0, exp_dc_read});
      check("dc_write", {31'b0, dc_write}, {31'b0, exp_dc_write});
      check("bus_err", {31'b0, bus_err}, {31'b0, exp_bus_err});
      check("err_addr", {2'b0, err_addr}, {2'b0, exp_err_addr});
      if (chk_rdata) check("cpu_rdata", cpu_rdata, exp_rdata);
      if (chk_lat) begin
        check("dev_we", {31'b0, dev_we}, {31'b0, exp_we});
        check("dev_addr", {2'b0, dev_addr}, {2'b0, exp_addr});
        check("dev_wdata", dev_wdata, exp_wdata);
        check("dev_byte_en", {28'b0, dev_byte_en}, {28'b0, exp_be});
      end
    end
  end

  task automatic rand_dev_rdata();
    for (int i = 0; i < int'(NDEV); i++) dev_rdata[32*i +: 32] = $urandom;
  endtask

  // One clock: observe at the falling edge, then move to just after the next rising edge
  task automatic tick(inout int stall_cnt, inout int busy_cnt, inout logic [NDEV-1:0] req_seen,
                      output logic [31:0] rd);
    @(negedge clk);
    if (cpu_stall === 1'b1) stall_cnt++;
    if (dev_req !== '0) busy_cnt++;
    req_seen = req_seen | dev_req;
    rd = cpu_rdata;
    @(posedge clk);
    #1;
  endtask

  // One pipeline access. ack_at: BUSY cycle (1-based) in which the device acks; 0 = never.
  // data: device read data for the ack, or cache data for a pass-through access.
  task automatic txn(input logic [29:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                     input logic [3:0] be, input int ack_at, input logic [31:0] data,
                     input bit stray, output int stall_cnt, output int busy_cnt,
                     output logic [NDEV-1:0] req_seen, output logic [31:0] done_rdata);
    int          sel, busy_len;
    bit          to;
    logic [31:0] r;
    stall_cnt = 0;
    busy_cnt  = 0;
    req_seen  = '0;
    sel = model_sel(a, rd | wr);
    cpu_addr = a; cpu_read = rd; cpu_write = wr; cpu_wdata = wd; cpu_byte_en = be;
    dev_ack = '0;
    rand_dev_rdata();
    chk_en = 1'b1;
    exp_req = '0;
    exp_dc_read  = rd & (sel < 0);
    exp_dc_write = wr & (sel < 0);
    if (sel < 0) begin
      dc_rdata  = data;
      exp_stall = 1'b0;
      chk_rdata = 1'b1;
      exp_rdata = data;
      chk_lat   = 1'b0;
      tick(stall_cnt, busy_cnt, req_seen, done_rdata);
      return;
    end
    dc_rdata = $urandom;
    to       = !(ack_at >= 1 && ack_at <= int'(TMO));
    busy_len = to ? int'(TMO) : ack_at;
    // Request cycle
    exp_stall = 1'b1;
    chk_rdata = 1'b0;
    chk_lat   = 1'b0;
    tick(stall_cnt, busy_cnt, req_seen, r);
    // Waiting for the device
    chk_lat   = 1'b1;
    exp_we    = wr; exp_addr = a; exp_wdata = wd; exp_be = be;
    exp_req   = NDEV'(1) << sel;
    for (int k = 1; k <= busy_len; k++) begin
      rand_dev_rdata();
      dev_ack = stray ? (NDEV'($urandom) & ~(NDEV'(1) << sel)) : '0;
      if (!to && k == ack_at) begin
        dev_ack[sel] = 1'b1;
        dev_rdata[32*sel +: 32] = data;
      end
      tick(stall_cnt, busy_cnt, req_seen, r);
    end
    // Completion cycle
    dev_ack   = '0;
    rand_dev_rdata();
    exp_req   = '0;
    exp_stall = 1'b0;
    chk_rdata = 1'b1;
    exp_rdata = to ? ERRD : data;
    if (to) begin
      if (!exp_bus_err) exp_err_addr = a;
      exp_bus_err = 1'b1;
    end
    tick(stall_cnt, busy_cnt, req_seen, done_rdata);
  endtask

  // Quiet cycle with no access; optionally also confirm the latched fields are at reset values
  task automatic idle_cycle(input bit lat_zero);
    int          s, b;
    logic [NDEV-1:0] q;
    logic [31:0] r;
    cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_addr = 30'(($urandom));
    dc_rdata = $urandom;
    exp_stall = 1'b0; exp_req = '0; exp_dc_read = 1'b0; exp_dc_write = 1'b0;
    chk_rdata = 1'b1; exp_rdata = dc_rdata;
    chk_lat = lat_zero;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    s = 0; b = 0; q = '0;
    tick(s, b, q, r);
  endtask

  int              sc, bc;
  logic [NDEV-1:0] rq;
  logic [31:0]     dr;

  initial begin
    rst = 1'b1; in_rst = 1'b1; chk_en = 1'b0; chk_rdata = 1'b0; chk_lat = 1'b0;
    cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0; cpu_byte_en = '0;
    dc_rdata = '0; dev_rdata = '0; dev_ack = '0;
    exp_bus_err = 1'b0; exp_err_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_rst = 1'b0; chk_en = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Cache pass-through
    txn(30'h0000100, 1'b1, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, sc, bc, rq, dr);
    check("pt_rdata", dr, 32'h1234_5678);
    check("pt_stall", sc, 0);

    // Device write, fast ack on dev0
    txn(30'h3000_0010, 1'b0, 1'b1, 32'h41, 4'b1000, 1, 32'h0, 1'b0, sc, bc, rq, dr);
    check("wr_stall_cycles", sc, 2);
    check("wr_busy_cycles", bc, 1);
    check("wr_req", {27'b0, rq}, 32'h1);

    // Device read, slow ack on dev3
    txn(30'h3C00_0020, 1'b1, 1'b0, 32'h0, 4'hF, 5, 32'hCAFE_0001, 1'b0, sc, bc, rq, dr);
    check("slow_stall_cycles", sc, 6);
    check("slow_rdata", dr, 32'hCAFE_0001);
    check("slow_req", {27'b0, rq}, 32'h8);
    check("slow_bus_err", {31'b0, bus_err}, 32'h0);

    // Ack in the very cycle the timeout would fire
    txn(30'h3000_0200, 1'b1, 1'b0, 32'h0, 4'hF, int'(TMO), 32'h5A5A_0003, 1'b0, sc, bc, rq, dr);
    check("coinc_stall_cycles", sc, int'(TMO) + 1);
    check("coinc_rdata", dr, 32'h5A5A_0003);
    check("coinc_bus_err", {31'b0, bus_err}, 32'h0);

    // dev1 transaction with stray acks on every other channel
    txn(30'h3400_0008, 1'b1, 1'b0, 32'h0, 4'hF, 4, 32'h0BAD_F00D, 1'b1, sc, bc, rq, dr);
    check("stray_stall_cycles", sc, 5);
    check("stray_rdata", dr, 32'h0BAD_F00D);

    // Timeout on tag D: duplicate tag resolves to dev1
    txn(30'h3400_0123, 1'b1, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b1, sc, bc, rq, dr);
    check("to_stall_cycles", sc, int'(TMO) + 1);
    check("to_rdata", dr, 32'hDEAD_BEEF);
    check("to_req", {27'b0, rq}, 32'h2);
    check("to_bus_err", {31'b0, bus_err}, 32'h1);
    check("to_err_addr", {2'b0, err_addr}, 32'h3400_0123);

    // Second timeout keeps the first error address
    txn(30'h3800_0444, 1'b0, 1'b1, 32'h77, 4'h1, 0, 32'h0, 1'b0, sc, bc, rq, dr);
    check("to2_err_addr", {2'b0, err_addr}, 32'h3400_0123);

    // Reset while dev2 is busy
    cpu_addr = 30'h3800_0010; cpu_read = 1'b1; cpu_write = 1'b0;
    cpu_wdata = 32'h0; cpu_byte_en = 4'hF; dev_ack = '0;
    exp_stall = 1'b1; exp_req = '0; exp_dc_read = 1'b0; exp_dc_write = 1'b0;
    chk_rdata = 1'b0; chk_lat = 1'b0;
    tick(sc, bc, rq, dr);
    exp_req = NDEV'(4);
    repeat (2) tick(sc, bc, rq, dr);
    rst = 1'b1; in_rst = 1'b1;
    tick(sc, bc, rq, dr);
    rst = 1'b0; in_rst = 1'b0;
    exp_bus_err = 1'b0; exp_err_addr = '0;
    idle_cycle(1'b1);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    dev_ack = NDEV'(4);
    idle_cycle(1'b1);
    dev_ack = '0;
    idle_cycle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic [29:0] a;
      logic        rd, wr;
      int          op, ack_at, pick;
      a  = {4'($urandom_range(0, 15)), 26'($urandom)};
      op = $urandom_range(0, 3);
      rd = (op == 1) || (op == 3);
      wr = (op == 2);
      pick = $urandom_range(0, 9);
      if (pick == 0)      ack_at = 0;
      else if (pick == 1) ack_at = int'(TMO);
      else if (pick == 2) ack_at = int'(TMO) - 1;
      else                ack_at = $urandom_range(1, 6);
      txn(a, rd, wr, $urandom, 4'($urandom), ack_at, $urandom, 1'($urandom), sc, bc, rq, dr);
      if ($urandom_range(0, 4) == 0) idle_cycle(1'b0);
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
